// File: rtl/ivs_ahb_pkg.sv
// Shared encodings for the IVS AHB-lite master: bus constants, response codes,
// FSM state type and the slave-window decode helper.
package ivs_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE     = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ   = 2'b10;

    localparam logic [2:0] HSIZE_WORD      = 3'b010;
    localparam logic [2:0] HBURST_SINGLE   = 3'b000;
    localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

    localparam logic [1:0] RSP_OK      = 2'd0;
    localparam logic [1:0] RSP_HRESP   = 2'd1;
    localparam logic [1:0] RSP_DECODE  = 2'd2;
    localparam logic [1:0] RSP_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } ahb_state_t;

    // A command misses when it falls outside the slave window or is not word aligned.
    function automatic logic decode_miss(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] mask);
        return ((addr & mask) != base) || (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/ivs_ahb_mst.sv
// Single-outstanding AHB-lite master: one register command in, one AHB single
// transfer out, one response (read data + status) back.
module ivs_ahb_mst
    import ivs_ahb_pkg::*;
#(
    parameter logic [31:0] SLV_BASE    = 32'h0000_0000,
    parameter logic [31:0] SLV_MASK    = 32'hFFFF_F000,
    parameter int          TIMEOUT_CYC = 16
) (
    input  logic        hclk,
    input  logic        hrst,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err,

    output logic        hsel,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [31:0] haddr,
    output logic [31:0] hwdata,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [3:0]  hprot,
    output logic        hready,

    input  logic        hready_resp,
    input  logic [1:0]  hresp,
    input  logic [31:0] hrdata,

    output logic        busy
);

    localparam int              TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    ahb_state_t      state_reg;
    logic            write_reg;
    logic [31:0]     wdata_reg;
    logic [TO_W-1:0] to_cnt_reg;

    assign hsize  = HSIZE_WORD;
    assign hburst = HBURST_SINGLE;
    assign hprot  = HPROT_DATA_PRIV;
    // The slave's hready_in must see its own hready_out: there is no other master.
    assign hready = hready_resp;

    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            state_reg  <= ST_IDLE;
            write_reg  <= 1'b0;
            wdata_reg  <= 32'h0;
            to_cnt_reg <= '0;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'h0;
            rsp_err    <= RSP_OK;
            hsel       <= 1'b0;
            htrans     <= HTRANS_IDLE;
            hwrite     <= 1'b0;
            haddr      <= 32'h0;
            hwdata     <= 32'h0;
            busy       <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        write_reg <= cmd_write;
                        wdata_reg <= cmd_wdata;
                        if (decode_miss(cmd_addr, SLV_BASE, SLV_MASK)) begin
                            state_reg <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= RSP_DECODE;
                            rsp_rdata <= 32'h0;
                        end else begin
                            state_reg <= ST_ADDR;
                            hsel      <= 1'b1;
                            htrans    <= HTRANS_NONSEQ;
                            haddr     <= cmd_addr;
                            hwrite    <= cmd_write;
                        end
                    end
                end

                ST_ADDR: begin
                    // A low hready here can only come from a misbehaving slave; hold the address phase.
                    if (hready_resp) begin
                        state_reg  <= ST_DATA;
                        hsel       <= 1'b0;
                        htrans     <= HTRANS_IDLE;
                        hwdata     <= wdata_reg;
                        to_cnt_reg <= '0;
                    end
                end

                ST_DATA: begin
                    if (hready_resp) begin
                        state_reg <= ST_RESP;
                        rsp_valid <= 1'b1;
                        if (hresp != 2'b00) begin
                            rsp_err   <= RSP_HRESP;
                            rsp_rdata <= 32'h0;
                        end else begin
                            rsp_err   <= RSP_OK;
                            rsp_rdata <= write_reg ? 32'h0 : hrdata;
                        end
                    end else if (to_cnt_reg == TO_LAST) begin
                        state_reg <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= RSP_TIMEOUT;
                        rsp_rdata <= 32'h0;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + TO_W'(1);
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        state_reg <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                    cmd_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ivs_ahb_mst.sv
// Self-checking bench for ivs_ahb_mst: a stub IVS slave plus a transaction-level
// model predicting status, read data and response latency of every command.
module tb_ivs_ahb_mst;
    import ivs_ahb_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [31:0] MASK = 32'hFFFF_F000;
    localparam int          TO   = 16;

    localparam int M_NORMAL = 0;
    localparam int M_ERR    = 1;
    localparam int M_HANG   = 2;

    logic        hclk = 1'b0;
    logic        hrst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        hsel, hwrite, hready, busy;
    logic [1:0]  htrans;
    logic [31:0] haddr, hwdata;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic        hready_resp;
    logic [1:0]  hresp;
    logic [31:0] hrdata;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int chk_cnt  = 0;
    int stub_mode = M_NORMAL;
    int bus_cnt = 0;

    always #5 hclk = ~hclk;

    ivs_ahb_mst #(.SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT_CYC(TO)) dut (
        .hclk(hclk), .hrst(hrst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .hsel(hsel), .htrans(htrans), .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata),
        .hsize(hsize), .hburst(hburst), .hprot(hprot), .hready(hready),
        .hready_resp(hready_resp), .hresp(hresp), .hrdata(hrdata),
        .busy(busy)
    );

    // Stub IVS slave: one wait state normally, zero-wait error, or hready stuck low.
    logic [31:0] stub_mem [0:1023];
    logic        stub_dp, stub_wr;
    logic [31:0] stub_addr;

    initial for (int i = 0; i < 1024; i++) stub_mem[i] = 32'h0;

    always @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            hready_resp <= 1'b1;
            hresp       <= 2'b00;
            hrdata      <= 32'h0;
            stub_dp     <= 1'b0;
            stub_wr     <= 1'b0;
            stub_addr   <= 32'h0;
        end else begin
            if (stub_dp) begin
                if (hready_resp) begin
                    if (stub_wr) stub_mem[stub_addr[11:2]] <= hwdata;
                    stub_dp <= 1'b0;
                    hresp   <= 2'b00;
                end else if (stub_mode != M_HANG) begin
                    hready_resp <= 1'b1;
                    hrdata      <= stub_wr ? 32'h0 : stub_mem[stub_addr[11:2]];
                end
            end
            if (hsel && htrans == HTRANS_NONSEQ && hready) begin
                stub_dp   <= 1'b1;
                stub_addr <= haddr;
                stub_wr   <= hwrite;
                if (stub_mode == M_ERR) begin
                    hready_resp <= 1'b1;
                    hresp       <= 2'b01;
                    hrdata      <= 32'hBAD0_BAD0;
                end else begin
                    hready_resp <= 1'b0;
                end
            end
        end
    end

    always @(posedge hclk) if (hsel || htrans != HTRANS_IDLE) bus_cnt <= bus_cnt + 1;

    logic [31:0] ref_mem [logic [31:0]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Transaction-level prediction straight from the command and slave behaviour.
    task automatic model(input logic wr, input logic [31:0] a, input logic [31:0] wd, input int mode,
                         output logic [31:0] e_rdata, output logic [1:0] e_err, output int e_lat);
        logic [1:0] lo;
        lo = a[1:0];
        e_rdata = 32'h0;
        if ((a & MASK) != BASE || lo != 2'b00) begin
            e_err = 2'd2; e_lat = 1;
        end else if (mode == M_ERR) begin
            e_err = 2'd1; e_lat = 3;
        end else if (mode == M_HANG) begin
            e_err = 2'd3; e_lat = TO + 2;
        end else begin
            e_err = 2'd0; e_lat = 4;
            if (wr) ref_mem[a] = wd;
            else if (ref_mem.exists(a)) e_rdata = ref_mem[a];
        end
    endtask

    // Presents a command and returns at the negedge of the cycle after acceptance.
    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] wd);
        int t;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
        t = 0;
        while (!cmd_ready && t < 60) begin
            @(negedge hclk); t++;
        end
        check("accept", {31'h0, cmd_ready}, 32'h1);
        @(negedge hclk);
        cmd_valid = 1'b0;
    endtask

    task automatic await_rsp(input string tag, input logic [31:0] e_rdata, input logic [1:0] e_err,
                             input int e_lat);
        int lat;
        lat = 1;
        while (!rsp_valid && lat < 60) begin
            @(negedge hclk); lat++;
        end
        check({tag, "_valid"}, {31'h0, rsp_valid}, 32'h1);
        check({tag, "_lat"}, lat, e_lat);
        check({tag, "_err"}, {30'h0, rsp_err}, {30'h0, e_err});
        check({tag, "_rdata"}, rsp_rdata, e_rdata);
    endtask

    task automatic consume(input string tag);
        rsp_ready = 1'b1;
        @(negedge hclk);
        rsp_ready = 1'b0;
        check({tag, "_idle"}, {30'h0, cmd_ready, busy}, 32'h2);
    endtask

    task automatic do_cmd(input string tag, input logic wr, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] e_rdata;
        logic [1:0]  e_err;
        int          e_lat, bus0;
        model(wr, a, wd, stub_mode, e_rdata, e_err, e_lat);
        bus0 = bus_cnt;
        issue(wr, a, wd);
        await_rsp(tag, e_rdata, e_err, e_lat);
        if (e_err == 2'd2) check({tag, "_nobus"}, bus_cnt - bus0, 0);
        consume(tag);
        $display("txn %-10s wr=%0d addr=%h wdata=%h -> err=%0d rdata=%h", tag, wr, a, wd, rsp_err, rsp_rdata);
    endtask

    initial begin
        logic [31:0] a, d, e_rdata;
        logic [1:0]  e_err;
        int          e_lat;
        hrst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge hclk);
        hrst = 1'b0;
        @(negedge hclk);
        check("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        check("rst_rsp", {rsp_valid, busy, hsel, hwrite, htrans, rsp_err}, 8'h00);
        check("rst_haddr", haddr, 32'h0);
        check("rst_hwdata", hwdata, 32'h0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("const_ctrl", {hsize, hburst, hprot}, {3'b010, 3'b000, 4'b0011});

        // rsp_ready asserted while idle must not create a response
        rsp_ready = 1'b1;
        repeat (3) @(negedge hclk);
        check("idle_rsp_ready", {31'h0, rsp_valid}, 32'h0);
        rsp_ready = 1'b0;

        do_cmd("wr100", 1'b1, 32'h100, 32'hDEAD_BEEF);
        do_cmd("rd100", 1'b0, 32'h100, 32'h0);
        do_cmd("miss_win", 1'b0, 32'h0000_2000, 32'h0);
        do_cmd("miss_algn", 1'b0, 32'h102, 32'h0);
        do_cmd("miss_wr", 1'b1, 32'h8000_0010, 32'h1234_5678);

        stub_mode = M_HANG;
        do_cmd("timeout", 1'b0, 32'h010, 32'h0);
        stub_mode = M_NORMAL;
        for (int i = 0; i < 6; i++) begin
            @(negedge hclk);
            check("late_hready", {31'h0, rsp_valid}, 32'h0);
        end

        stub_mode = M_ERR;
        do_cmd("hresp_err", 1'b0, 32'h100, 32'h0);
        stub_mode = M_NORMAL;

        // Response backpressure with a second command waiting
        do_cmd("wr000", 1'b1, 32'h000, 32'hA5A5_0F0F);
        model(1'b0, 32'h000, 32'h0, M_NORMAL, e_rdata, e_err, e_lat);
        issue(1'b0, 32'h000, 32'h0);
        await_rsp("rd000", e_rdata, e_err, e_lat);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h008; cmd_wdata = 32'h0BAD_CAFE;
        for (int i = 0; i < 10; i++) begin
            @(negedge hclk);
            check("bp_valid", {31'h0, rsp_valid}, 32'h1);
            check("bp_rdata", rsp_rdata, e_rdata);
            check("bp_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        end
        rsp_ready = 1'b1;
        @(negedge hclk);
        rsp_ready = 1'b0;
        check("bp_accept_next", {31'h0, cmd_ready}, 32'h1);
        model(1'b1, 32'h008, 32'h0BAD_CAFE, M_NORMAL, e_rdata, e_err, e_lat);
        @(negedge hclk);
        cmd_valid = 1'b0;
        check("bp_taken", {31'h0, cmd_ready}, 32'h0);
        await_rsp("wr008", e_rdata, e_err, e_lat);
        consume("wr008");
        do_cmd("rd008", 1'b0, 32'h008, 32'h0);

        // Asynchronous reset in the middle of a write data phase
        issue(1'b1, 32'h104, 32'h5555_AAAA);
        @(negedge hclk);
        check("pre_rst_busy", {30'h0, busy, hsel}, 32'h2);
        #1 hrst = 1'b1;
        #1;
        check("arst_ctrl", {cmd_ready, rsp_valid, busy, hsel, hwrite, htrans, rsp_err}, 9'h100);
        check("arst_haddr", haddr, 32'h0);
        check("arst_hwdata", hwdata, 32'h0);
        check("arst_rdata", rsp_rdata, 32'h0);
        @(negedge hclk);
        hrst = 1'b0;
        @(negedge hclk);
        do_cmd("wr104", 1'b1, 32'h104, 32'h7777_1111);
        do_cmd("rd104", 1'b0, 32'h104, 32'h0);

        // Randomised mix of in-window, out-of-window and misaligned accesses
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0:       a = {$urandom_range(1, 15) << 12} | ($urandom_range(0, 1023) << 2);
                1:       a = ($urandom_range(0, 1023) << 2) | $urandom_range(1, 3);
                default: a = $urandom_range(0, 15) << 2;
            endcase
            d = $urandom;
            do_cmd($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), a, d);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
